// File: rtl/arp_resolver_ctrl_if.sv
// ARP resolver control bus: frame input, lookup request/response, TX frame
// output, cache update and station addresses. clk/rst_n stay plain ports.
interface arp_resolver_ctrl_if;
   logic [47:0] local_mac;
   logic [31:0] local_ip;

   logic        s_frame_valid;
   logic        s_frame_ready;
   logic [15:0] s_frame_oper;
   logic [47:0] s_frame_sha;
   logic [31:0] s_frame_spa;
   logic [31:0] s_frame_tpa;

   logic        s_lookup_valid;
   logic        s_lookup_ready;
   logic [31:0] s_lookup_ip;

   logic        m_lookup_resp_valid;
   logic [47:0] m_lookup_resp_mac;
   logic        m_lookup_resp_error;

   logic        m_tx_valid;
   logic        m_tx_ready;
   logic [15:0] m_tx_oper;
   logic [47:0] m_tx_dest_mac;
   logic [47:0] m_tx_tha;
   logic [31:0] m_tx_tpa;

   logic        cache_wr_en;
   logic [31:0] cache_wr_ip;
   logic [47:0] cache_wr_mac;

   logic        busy;

   // Resolver side
   modport slave (
      input  local_mac, local_ip,
      input  s_frame_valid, s_frame_oper, s_frame_sha, s_frame_spa, s_frame_tpa,
      output s_frame_ready,
      input  s_lookup_valid, s_lookup_ip,
      output s_lookup_ready,
      output m_lookup_resp_valid, m_lookup_resp_mac, m_lookup_resp_error,
      output m_tx_valid, m_tx_oper, m_tx_dest_mac, m_tx_tha, m_tx_tpa,
      input  m_tx_ready,
      output cache_wr_en, cache_wr_ip, cache_wr_mac,
      output busy
   );

   // Environment side
   modport master (
      output local_mac, local_ip,
      output s_frame_valid, s_frame_oper, s_frame_sha, s_frame_spa, s_frame_tpa,
      input  s_frame_ready,
      output s_lookup_valid, s_lookup_ip,
      input  s_lookup_ready,
      input  m_lookup_resp_valid, m_lookup_resp_mac, m_lookup_resp_error,
      input  m_tx_valid, m_tx_oper, m_tx_dest_mac, m_tx_tha, m_tx_tpa,
      output m_tx_ready,
      input  cache_wr_en, cache_wr_ip, cache_wr_mac,
      input  busy
   );
endinterface

// File: rtl/arp_resolver_ctrl.sv
// ARP resolver: answers ARP requests for the local IP, learns senders into the
// cache, and resolves IP->MAC lookups with timed broadcast retries.
module arp_resolver_ctrl #(
   parameter int RETRY_COUNT    = 3,
   parameter int RETRY_INTERVAL = 1000
) (
   input logic                clk,
   input logic                rst_n,
   arp_resolver_ctrl_if.slave bus
);
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_ISSUE = 2'd1;
   localparam logic [1:0]  ST_WAIT  = 2'd2;
   localparam logic [1:0]  ST_RESP  = 2'd3;
   localparam logic [15:0] OPER_REQ = 16'd1;
   localparam logic [15:0] OPER_REP = 16'd2;
   localparam logic [23:0] TIMER_LOAD   = 24'(RETRY_INTERVAL - 1);
   localparam logic [3:0]  MAX_ATTEMPTS = 4'(RETRY_COUNT);

   logic [1:0]  state;
   logic        run;            // keeps the ready outputs low until the first clk after reset
   logic        reply_pending, request_pending;
   logic [47:0] rp_mac;
   logic [31:0] rp_tpa;
   logic [31:0] pending_ip;
   logic [3:0]  attempts;
   logic [23:0] timer;
   logic        tx_valid;
   logic [15:0] tx_oper;
   logic [47:0] tx_dest, tx_tha;
   logic [31:0] tx_tpa;
   logic        cwr_en;
   logic [31:0] cwr_ip;
   logic [47:0] cwr_mac;
   logic        resp_valid, resp_err;
   logic [47:0] resp_mac;

   logic frame_fire, is_req_me, is_reply, lookup_fire;
   logic tx_load, load_reply, load_req, tx_req_fire, match;

   assign bus.s_frame_ready  = run && !reply_pending;
   assign bus.s_lookup_ready = run && (state == ST_IDLE);
   assign frame_fire  = bus.s_frame_valid && bus.s_frame_ready;
   assign is_req_me   = (bus.s_frame_oper == OPER_REQ) && (bus.s_frame_tpa == bus.local_ip);
   assign is_reply    = (bus.s_frame_oper == OPER_REP);
   assign lookup_fire = bus.s_lookup_valid && bus.s_lookup_ready;
   // TX register refills when empty or draining this cycle; replies go first
   assign tx_load     = !tx_valid || bus.m_tx_ready;
   assign load_reply  = tx_load && reply_pending;
   assign load_req    = tx_load && !reply_pending && request_pending;
   assign tx_req_fire = tx_valid && bus.m_tx_ready && (tx_oper == OPER_REQ);
   assign match       = frame_fire && is_reply && (bus.s_frame_spa == pending_ip) &&
                        ((state == ST_ISSUE) || (state == ST_WAIT));

   assign bus.m_tx_valid          = tx_valid;
   assign bus.m_tx_oper           = tx_oper;
   assign bus.m_tx_dest_mac       = tx_dest;
   assign bus.m_tx_tha            = tx_tha;
   assign bus.m_tx_tpa            = tx_tpa;
   assign bus.cache_wr_en         = cwr_en;
   assign bus.cache_wr_ip         = cwr_ip;
   assign bus.cache_wr_mac        = cwr_mac;
   assign bus.m_lookup_resp_valid = resp_valid;
   assign bus.m_lookup_resp_mac   = resp_mac;
   assign bus.m_lookup_resp_error = resp_err;
   assign bus.busy                = (state != ST_IDLE);

   // Run flag: ready outputs come up one clk after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run <= 1'b0;
      else        run <= 1'b1;
   end

   // Frame intake: cache learning and capture of a reply to send back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reply_pending <= 1'b0;
         rp_mac        <= '0;
         rp_tpa        <= '0;
         cwr_en        <= 1'b0;
         cwr_ip        <= '0;
         cwr_mac       <= '0;
      end else begin
         cwr_en <= 1'b0;
         if (frame_fire && (is_req_me || is_reply)) begin
            cwr_en  <= 1'b1;
            cwr_ip  <= bus.s_frame_spa;
            cwr_mac <= bus.s_frame_sha;
         end
         if (frame_fire && is_req_me) begin
            reply_pending <= 1'b1;
            rp_mac        <= bus.s_frame_sha;
            rp_tpa        <= bus.s_frame_spa;
         end else if (load_reply) begin
            reply_pending <= 1'b0;
         end
      end
   end

   // TX holding register: fields stay stable until m_tx_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
         tx_oper  <= '0;
         tx_dest  <= '0;
         tx_tha   <= '0;
         tx_tpa   <= '0;
      end else if (load_reply) begin
         tx_valid <= 1'b1;
         tx_oper  <= OPER_REP;
         tx_dest  <= rp_mac;
         tx_tha   <= rp_mac;
         tx_tpa   <= rp_tpa;
      end else if (load_req) begin
         tx_valid <= 1'b1;
         tx_oper  <= OPER_REQ;
         tx_dest  <= 48'hFFFF_FFFF_FFFF;
         tx_tha   <= '0;
         tx_tpa   <= pending_ip;
      end else if (tx_load) begin
         tx_valid <= 1'b0;
      end
   end

   // Lookup FSM: issue request, wait with timeout, retry, then respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         request_pending <= 1'b0;
         pending_ip      <= '0;
         attempts        <= '0;
         timer           <= '0;
         resp_valid      <= 1'b0;
         resp_err        <= 1'b0;
         resp_mac        <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (load_req) request_pending <= 1'b0;
         case (state)
            ST_IDLE: if (lookup_fire) begin
               pending_ip <= bus.s_lookup_ip;
               attempts   <= '0;
               if (bus.s_lookup_ip == bus.local_ip) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_mac   <= bus.local_mac;
                  resp_err   <= 1'b0;
               end else begin
                  state           <= ST_ISSUE;
                  request_pending <= 1'b1;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (match) begin
                  // a request already in the TX register still goes out
                  state           <= ST_RESP;
                  resp_valid      <= 1'b1;
                  resp_mac        <= bus.s_frame_sha;
                  resp_err        <= 1'b0;
                  request_pending <= 1'b0;
               end else if (state == ST_ISSUE) begin
                  if (tx_req_fire) begin
                     attempts <= attempts + 4'd1;
                     timer    <= TIMER_LOAD;
                     state    <= ST_WAIT;
                  end
               end else if (timer == '0) begin
                  if (attempts < MAX_ATTEMPTS) begin
                     state           <= ST_ISSUE;
                     request_pending <= 1'b1;
                  end else begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_mac   <= '0;
                     resp_err   <= 1'b1;
                  end
               end else begin
                  timer <= timer - 24'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_arp_resolver_ctrl.sv
// Self-checking bench for arp_resolver_ctrl: directed frame/TX scenarios plus
// randomized lookups checked against an arithmetic retry/timing model.
module tb_arp_resolver_ctrl;
   localparam int          RC   = 3;
   localparam int          RI   = 20;
   localparam logic [31:0] LIP  = 32'h0A00_0001;
   localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic [31:0] rip;
   logic [47:0] rmac;
   int          q_oper[$];
   logic [31:0] q_tpa[$];
   int          seen_resp, seen_tx;

   arp_resolver_ctrl_if bus ();

   arp_resolver_ctrl #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [15:0] op, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [31:0] tpa);
      int n = 0;
      while (!bus.s_frame_ready && n < 100) begin tick(); n++; end
      chk("frame_ready_wait", bus.s_frame_ready, 1'b1);
      bus.s_frame_oper = op; bus.s_frame_sha = sha;
      bus.s_frame_spa = spa; bus.s_frame_tpa = tpa;
      bus.s_frame_valid = 1'b1;
      tick();
      bus.s_frame_valid = 1'b0;
   endtask

   // Lookup with m_tx_ready=1. Model: accept edge a; request k (0-based) loads
   // at a+1+k*(RI+2) and handshakes one edge later; timeout decides at
   // last = a+2+(RC-1)*(RI+2)+RI. A matching reply accepted at edge r<=last
   // wins; requests already loaded by edge r still go out. roff<0: no reply.
   task automatic lookup_run(input logic [31:0] ip, input int roff, input logic [47:0] mac);
      int a, r, last, resp_at, nexp, resp_cnt, resp_cyc, stop;
      logic [47:0] got_mac;
      logic got_err, ok_exp, bcast_ok;
      int hs[$];
      chk("lk_ready", bus.s_lookup_ready, 1'b1);
      bus.s_lookup_ip = ip; bus.s_lookup_valid = 1'b1;
      tick();
      bus.s_lookup_valid = 1'b0;
      a = cyc;
      last = a + 2 + (RC - 1) * (RI + 2) + RI;
      r = (roff >= 0) ? a + 1 + roff : -1;
      ok_exp = (r >= 0) && (r <= last);
      resp_at = ok_exp ? r : last;
      nexp = 0;
      for (int k = 0; k < RC; k++) if (!ok_exp || (a + 1 + k * (RI + 2) <= r)) nexp++;
      resp_cnt = 0; resp_cyc = -1; got_mac = '0; got_err = 1'b0; bcast_ok = 1'b1;
      stop = resp_at + 4;
      while (cyc < stop) begin
         if (cyc + 1 == r) begin
            bus.s_frame_oper = 16'd2; bus.s_frame_sha = mac;
            bus.s_frame_spa = ip; bus.s_frame_tpa = LIP;
            bus.s_frame_valid = 1'b1;
         end
         if (bus.m_tx_valid && bus.m_tx_ready && bus.m_tx_oper == 16'd1) begin
            hs.push_back(cyc + 1);
            if (bus.m_tx_dest_mac !== 48'hFFFF_FFFF_FFFF || bus.m_tx_tha !== 48'd0 ||
                bus.m_tx_tpa !== ip) bcast_ok = 1'b0;
         end
         tick();
         bus.s_frame_valid = 1'b0;
         if (bus.m_lookup_resp_valid) begin
            resp_cnt++; resp_cyc = cyc;
            got_mac = bus.m_lookup_resp_mac; got_err = bus.m_lookup_resp_error;
         end
      end
      chk("resp_count", resp_cnt, 1);
      chk("resp_cycle", resp_cyc, resp_at);
      chk("resp_mac", got_mac, ok_exp ? mac : 48'd0);
      chk("resp_error", got_err, !ok_exp);
      chk("req_count", hs.size(), nexp);
      chk("req_fields", bcast_ok, 1'b1);
      foreach (hs[k]) chk("req_edge", hs[k], a + 2 + k * (RI + 2));
      chk("busy_end", bus.busy, 1'b0);
   endtask

   initial begin
      bus.local_ip = LIP; bus.local_mac = LMAC;
      bus.s_frame_valid = 1'b0; bus.s_frame_oper = '0; bus.s_frame_sha = '0;
      bus.s_frame_spa = '0; bus.s_frame_tpa = '0;
      bus.s_lookup_valid = 1'b0; bus.s_lookup_ip = '0;
      bus.m_tx_ready = 1'b1;
      #1;
      // reset state
      chk("rst_frame_ready", bus.s_frame_ready, 1'b0);
      chk("rst_lookup_ready", bus.s_lookup_ready, 1'b0);
      chk("rst_tx_valid", bus.m_tx_valid, 1'b0);
      chk("rst_resp_valid", bus.m_lookup_resp_valid, 1'b0);
      chk("rst_cache_wr", bus.cache_wr_en, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      chk("rel_frame_ready_low", bus.s_frame_ready, 1'b0);
      tick();
      chk("rel_frame_ready", bus.s_frame_ready, 1'b1);
      chk("rel_lookup_ready", bus.s_lookup_ready, 1'b1);

      // ARP request for us -> cache write and reply frame
      bus.m_tx_ready = 1'b0;
      send_frame(16'd1, 48'h02_00_00_00_00_02, 32'h0A00_0002, LIP);
      chk("req_cache_en", bus.cache_wr_en, 1'b1);
      chk("req_cache_ip", bus.cache_wr_ip, 32'h0A00_0002);
      chk("req_cache_mac", bus.cache_wr_mac, 48'h02_00_00_00_00_02);
      chk("req_frame_ready", bus.s_frame_ready, 1'b0);
      tick();
      chk("req_cache_pulse", bus.cache_wr_en, 1'b0);
      chk("rep_valid", bus.m_tx_valid, 1'b1);
      chk("rep_oper", bus.m_tx_oper, 16'd2);
      chk("rep_dest", bus.m_tx_dest_mac, 48'h02_00_00_00_00_02);
      chk("rep_tha", bus.m_tx_tha, 48'h02_00_00_00_00_02);
      chk("rep_tpa", bus.m_tx_tpa, 32'h0A00_0002);
      tick(); tick();
      chk("rep_hold_valid", bus.m_tx_valid, 1'b1);
      chk("rep_hold_tpa", bus.m_tx_tpa, 32'h0A00_0002);
      bus.m_tx_ready = 1'b1;
      tick();
      chk("rep_drained", bus.m_tx_valid, 1'b0);

      // dropped frames
      send_frame(16'd1, 48'h02_00_00_00_00_33, 32'h0A00_0033, LIP + 32'd5);
      chk("drop_other_tpa_cache", bus.cache_wr_en, 1'b0);
      tick();
      chk("drop_other_tpa_tx", bus.m_tx_valid, 1'b0);
      send_frame(16'd3, 48'h02_00_00_00_00_44, 32'h0A00_0044, LIP);
      chk("drop_oper3_cache", bus.cache_wr_en, 1'b0);
      tick();
      chk("drop_oper3_tx", bus.m_tx_valid, 1'b0);

      // unsolicited reply while idle: learned, no response
      send_frame(16'd2, 48'h02_00_00_00_00_55, 32'h0A00_0055, 32'h0A00_00FE);
      chk("unsol_cache_en", bus.cache_wr_en, 1'b1);
      chk("unsol_cache_ip", bus.cache_wr_ip, 32'h0A00_0055);
      tick();
      chk("unsol_no_resp", bus.m_lookup_resp_valid, 1'b0);

      // lookup of own address
      bus.s_lookup_ip = LIP; bus.s_lookup_valid = 1'b1;
      tick();
      bus.s_lookup_valid = 1'b0;
      chk("self_resp_valid", bus.m_lookup_resp_valid, 1'b1);
      chk("self_resp_mac", bus.m_lookup_resp_mac, LMAC);
      chk("self_resp_err", bus.m_lookup_resp_error, 1'b0);
      chk("self_busy", bus.busy, 1'b1);
      chk("self_no_tx", bus.m_tx_valid, 1'b0);
      tick();
      chk("self_resp_pulse", bus.m_lookup_resp_valid, 1'b0);
      chk("self_idle", bus.busy, 1'b0);
      chk("self_no_tx2", bus.m_tx_valid, 1'b0);

      // single request then reply; full timeout
      lookup_run(32'h0A00_0009, 20, 48'h0A_0B_0C_0D_0E_0F);
      lookup_run(32'h0A00_0009, -1, 48'd0);
      // reply on the timer-expiry edge and on a reload edge
      lookup_run(32'h0A00_0019, 21, 48'h02_11_22_33_44_55);
      lookup_run(32'h0A00_0029, 22, 48'h02_66_77_88_99_AA);

      // randomized lookups
      repeat (8) begin
         rip  = {8'd10, 24'($urandom)};
         if (rip == LIP) rip = rip ^ 32'h0000_0100;
         rmac = {16'($urandom), 32'($urandom)};
         lookup_run(rip, int'($urandom_range(0, 70)), rmac);
      end

      // reply and request contend for a blocked TX register
      bus.m_tx_ready = 1'b0;
      send_frame(16'd1, 48'h02_00_00_00_0A_0A, 32'h0A00_00A0, LIP);
      tick();
      chk("ct_a_loaded", bus.m_tx_tpa, 32'h0A00_00A0);
      send_frame(16'd1, 48'h02_00_00_00_0B_0B, 32'h0A00_00B0, LIP);
      chk("ct_b_pending_ready", bus.s_frame_ready, 1'b0);
      chk("ct_lookup_ready", bus.s_lookup_ready, 1'b1);
      bus.s_lookup_ip = 32'h0A00_00C0; bus.s_lookup_valid = 1'b1;
      tick();
      bus.s_lookup_valid = 1'b0;
      tick(); tick();
      chk("ct_hold_ready", bus.s_frame_ready, 1'b0);
      chk("ct_hold_tpa", bus.m_tx_tpa, 32'h0A00_00A0);
      bus.m_tx_ready = 1'b1;
      repeat (5) begin
         if (bus.m_tx_valid && bus.m_tx_ready) begin
            q_oper.push_back(int'(bus.m_tx_oper));
            q_tpa.push_back(bus.m_tx_tpa);
         end
         tick();
      end
      chk("ct_count", q_oper.size(), 3);
      if (q_oper.size() == 3) begin
         chk("ct_first_oper", q_oper[0], 2);
         chk("ct_first_tpa", q_tpa[0], 32'h0A00_00A0);
         chk("ct_second_oper", q_oper[1], 2);
         chk("ct_second_tpa", q_tpa[1], 32'h0A00_00B0);
         chk("ct_third_oper", q_oper[2], 1);
         chk("ct_third_tpa", q_tpa[2], 32'h0A00_00C0);
      end
      send_frame(16'd2, 48'h02_CC_CC_CC_CC_CC, 32'h0A00_00C0, LIP);
      chk("ct_resp_valid", bus.m_lookup_resp_valid, 1'b1);
      chk("ct_resp_mac", bus.m_lookup_resp_mac, 48'h02_CC_CC_CC_CC_CC);
      tick();
      chk("ct_idle", bus.busy, 1'b0);

      // reset while waiting for a reply
      bus.s_lookup_ip = 32'h0A00_00D0; bus.s_lookup_valid = 1'b1;
      tick();
      bus.s_lookup_valid = 1'b0;
      tick(); tick(); tick();
      chk("mr_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy_cleared", bus.busy, 1'b0);
      chk("mr_tx_cleared", bus.m_tx_valid, 1'b0);
      chk("mr_resp_cleared", bus.m_lookup_resp_valid, 1'b0);
      chk("mr_frame_ready", bus.s_frame_ready, 1'b0);
      chk("mr_lookup_ready", bus.s_lookup_ready, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      seen_resp = 0; seen_tx = 0;
      repeat (80) begin
         tick();
         if (bus.m_lookup_resp_valid) seen_resp++;
         if (bus.m_tx_valid) seen_tx++;
      end
      chk("mr_no_resp", seen_resp, 0);
      chk("mr_no_tx", seen_tx, 0);
      chk("mr_new_ready", bus.s_lookup_ready, 1'b1);
      bus.s_lookup_ip = LIP; bus.s_lookup_valid = 1'b1;
      tick();
      bus.s_lookup_valid = 1'b0;
      chk("mr_new_resp", bus.m_lookup_resp_valid, 1'b1);
      chk("mr_new_mac", bus.m_lookup_resp_mac, LMAC);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
